// File: rtl/lockin_sequencer.sv
// -----------------------------------------------------------------------------
// lockin_sequencer
//   Acquisition and tracking controller for the half-rate lock-in datapath.
//   Sequences the datapath enable and clear, owns the drift-direction loopback
//   register, counts acquisition events and rate violations, and forces a
//   re-acquisition whenever lock is lost or acquisition times out.
//
// Ports
//   clk, arst_n                 clock, asynchronous active-low reset
//   clk_en                      clock enable; every register is qualified by it
//   enable_i, restart_i         controller enable / one-cycle restart request
//   acquire_timeout_i           events allowed in TRACK before giving up (0 = off)
//   max_violations_i            consecutive violations tolerated in LOCKED
//   polarity_filtered_event_i   qualified edge event from the datapath
//   active_rate_valid_i         rate register holds a valid rate
//   drift_detected_i            datapath drift flag
//   drift_direction_i           datapath drift direction (0 = late, 1 = early)
//   locked_in_i                 datapath lock status
//   rate_violation_i            datapath rate violation
//   lockin_en_o                 lock-in enable to datapath
//   clear_state_o               datapath clear, high throughout CLEAR
//   active_drift_direction_o    registered drift direction fed back to datapath
//   direction_valid_o           a direction was captured since the last clear
//   locked_o                    controller lock status
//   lock_lost_o                 one-cycle pulse when LOCKED drops to CLEAR
//   timeout_o                   one-cycle pulse when TRACK times out
//   state_o                     registered state encoding
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | controller disabled, all outputs low
// CLEAR   | datapath held in clear for HOLDOFF_CYCLES cycles
// ACQUIRE | waiting for a valid rate before enabling the datapath
// TRACK   | datapath enabled, counting events until lock or timeout
// LOCKED  | lock held, counting consecutive rate violations
// -----------------------------------------------------------------------------
module lockin_sequencer #(
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int VIOL_WIDTH     = 4,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     clk_en,
    input  logic                     enable_i,
    input  logic                     restart_i,
    input  logic [TIMEOUT_WIDTH-1:0] acquire_timeout_i,
    input  logic [VIOL_WIDTH-1:0]    max_violations_i,
    input  logic                     polarity_filtered_event_i,
    input  logic                     active_rate_valid_i,
    input  logic                     drift_detected_i,
    input  logic                     drift_direction_i,
    input  logic                     locked_in_i,
    input  logic                     rate_violation_i,
    output logic                     lockin_en_o,
    output logic                     clear_state_o,
    output logic                     active_drift_direction_o,
    output logic                     direction_valid_o,
    output logic                     locked_o,
    output logic                     lock_lost_o,
    output logic                     timeout_o,
    output logic [2:0]               state_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_ACQUIRE = 3'd2;
    localparam logic [2:0] S_TRACK   = 3'd3;
    localparam logic [2:0] S_LOCKED  = 3'd4;

    localparam logic PIN_CAME_LATE = 1'b0;

    localparam int HOLD_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

    logic [2:0]               r_state;
    logic [2:0]               w_state_next;
    logic [HOLD_W-1:0]        r_hold_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_evt_cnt;
    logic [VIOL_WIDTH-1:0]    r_viol_cnt;
    logic                     r_drift_dir;
    logic                     r_dir_valid;
    logic                     r_timeout;
    logic                     r_lock_lost;

    logic w_timeout_fire;
    logic w_timeout_hit;
    logic w_lost_hit;
    logic w_to_clear;
    logic w_drift_load;

    // Timeout fires on the event that would bring the count up to the limit.
    assign w_timeout_fire = polarity_filtered_event_i
                         && (acquire_timeout_i != '0)
                         && (r_evt_cnt == (acquire_timeout_i - TIMEOUT_WIDTH'(1)));

    // Counters and the valid flag are cleared on every cycle that lands in CLEAR,
    // so they are already zero for the whole time clear_state_o is high.
    assign w_to_clear   = (w_state_next == S_CLEAR);
    assign w_drift_load = drift_detected_i && ((r_state == S_TRACK) || (r_state == S_LOCKED));

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        w_lost_hit    = 1'b0;
        if (!enable_i) begin
            w_state_next = S_IDLE;
        end else if (restart_i && (r_state != S_IDLE)) begin
            w_state_next = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_CLEAR;
                end
                S_CLEAR: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_next = S_ACQUIRE;
                    end
                end
                S_ACQUIRE: begin
                    if (active_rate_valid_i) begin
                        w_state_next = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (locked_in_i) begin
                        w_state_next = S_LOCKED;
                    end else if (w_timeout_fire) begin
                        w_state_next  = S_CLEAR;
                        w_timeout_hit = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if ((rate_violation_i && (r_viol_cnt >= max_violations_i)) || !locked_in_i) begin
                        w_state_next = S_CLEAR;
                        w_lost_hit   = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Output logic: level outputs follow the registered state directly.
    always_comb begin
        lockin_en_o              = (r_state == S_TRACK) || (r_state == S_LOCKED);
        clear_state_o            = (r_state == S_CLEAR);
        locked_o                 = (r_state == S_LOCKED);
        lock_lost_o              = r_lock_lost;
        timeout_o                = r_timeout;
        active_drift_direction_o = r_drift_dir;
        direction_valid_o        = r_dir_valid;
        state_o                  = r_state;
    end

    // Holdoff, event and violation counters, pulses, drift loopback
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_hold_cnt  <= '0;
            r_evt_cnt   <= '0;
            r_viol_cnt  <= '0;
            r_drift_dir <= PIN_CAME_LATE;
            r_dir_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_lock_lost <= 1'b0;
        end else if (clk_en) begin
            r_timeout   <= w_timeout_hit;
            r_lock_lost <= w_lost_hit;

            // A restart while already in CLEAR begins the holdoff again.
            if (w_to_clear && (r_state == S_CLEAR) && !restart_i) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end

            if (w_to_clear) begin
                r_evt_cnt <= '0;
            end else if ((r_state == S_TRACK) && polarity_filtered_event_i && (r_evt_cnt != '1)) begin
                r_evt_cnt <= r_evt_cnt + TIMEOUT_WIDTH'(1);
            end

            if (w_to_clear) begin
                r_viol_cnt <= '0;
            end else if (r_state == S_LOCKED) begin
                if (rate_violation_i) begin
                    if (r_viol_cnt != '1) begin
                        r_viol_cnt <= r_viol_cnt + VIOL_WIDTH'(1);
                    end
                end else if (polarity_filtered_event_i) begin
                    r_viol_cnt <= '0;
                end
            end

            // The direction itself survives CLEAR; only its valid flag is dropped.
            if (w_drift_load) begin
                r_drift_dir <= drift_direction_i;
            end
            if (w_to_clear) begin
                r_dir_valid <= 1'b0;
            end else if (w_drift_load) begin
                r_dir_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lockin_sequencer.sv
module tb_lockin_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        clk_en;
    logic        enable_i;
    logic        restart_i;
    logic [15:0] acquire_timeout_i;
    logic [3:0]  max_violations_i;
    logic        polarity_filtered_event_i;
    logic        active_rate_valid_i;
    logic        drift_detected_i;
    logic        drift_direction_i;
    logic        locked_in_i;
    logic        rate_violation_i;
    logic        lockin_en_o;
    logic        clear_state_o;
    logic        active_drift_direction_o;
    logic        direction_valid_o;
    logic        locked_o;
    logic        lock_lost_o;
    logic        timeout_o;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    lockin_sequencer #(
        .TIMEOUT_WIDTH (16),
        .VIOL_WIDTH    (4),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .clk                      (clk),
        .arst_n                   (arst_n),
        .clk_en                   (clk_en),
        .enable_i                 (enable_i),
        .restart_i                (restart_i),
        .acquire_timeout_i        (acquire_timeout_i),
        .max_violations_i         (max_violations_i),
        .polarity_filtered_event_i(polarity_filtered_event_i),
        .active_rate_valid_i      (active_rate_valid_i),
        .drift_detected_i         (drift_detected_i),
        .drift_direction_i        (drift_direction_i),
        .locked_in_i              (locked_in_i),
        .rate_violation_i         (rate_violation_i),
        .lockin_en_o              (lockin_en_o),
        .clear_state_o            (clear_state_o),
        .active_drift_direction_o (active_drift_direction_o),
        .direction_valid_o        (direction_valid_o),
        .locked_o                 (locked_o),
        .lock_lost_o              (lock_lost_o),
        .timeout_o                (timeout_o),
        .state_o                  (state_o)
    );

    // stim: {clk_en, enable, restart, event, rate_valid, drift_det, drift_dir, locked_in, violation}
    // exp : {state[2:0], lockin_en, clear_state, locked, lock_lost, timeout, drift_dir, dir_valid}
    typedef struct packed {
        logic [8:0] stim;
        logic [9:0] exp;
    } vec_t;

    logic [9:0] w_out;
    assign w_out = {state_o, lockin_en_o, clear_state_o, locked_o, lock_lost_o,
                    timeout_o, active_drift_direction_o, direction_valid_o};

    // Common expectations with drift direction EARLY held and valid low.
    localparam logic [9:0] E_CLR_D1 = 10'b001_0_1_0_0_0_1_0;
    localparam logic [9:0] E_ACQ_D1 = 10'b010_0_0_0_0_0_1_0;
    localparam logic [9:0] E_TRK_D1 = 10'b011_1_0_0_0_0_1_0;
    localparam logic [9:0] E_LCK_D1 = 10'b100_1_0_1_0_0_1_0;
    localparam logic [9:0] E_TO_D1  = 10'b001_0_1_0_0_1_1_0;
    localparam logic [9:0] E_LL_D1  = 10'b001_0_1_0_1_0_1_0;

    localparam logic [8:0] S_RV     = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] S_RV_EV  = 9'b1_1_0_1_1_0_0_0_0;
    localparam logic [8:0] S_RV_LI  = 9'b1_1_0_0_1_0_0_1_0;

    int         checks   = 0;
    int         failures = 0;
    vec_t       tbl[$];
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string name, input logic [8:0] stim, input logic [9:0] expv);
        {clk_en, enable_i, restart_i, polarity_filtered_event_i, active_rate_valid_i,
         drift_detected_i, drift_direction_i, locked_in_i, rate_violation_i} = stim;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got %b", name, w_out);
        end else begin
            check(name, w_out, exp_q.pop_front());
        end
    endtask

    // From CLEAR (already entered) through the remaining holdoff into TRACK.
    task automatic finish_clear_to_track(input string name);
        for (int i = 0; i < 3; i++) apply(name, S_RV, E_CLR_D1);
        apply(name, S_RV, E_ACQ_D1);
        apply(name, S_RV, E_TRK_D1);
    endtask

    initial begin
        arst_n = 1'b0;
        {clk_en, enable_i, restart_i, polarity_filtered_event_i, active_rate_valid_i,
         drift_detected_i, drift_direction_i, locked_in_i, rate_violation_i} = 9'b1_0000_0000;
        acquire_timeout_i = 16'd20;
        max_violations_i  = 4'd2;

        // Basic lock, drift capture in TRACK, violation tolerance, back-to-back clear
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, 10'b001_0_1_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, 10'b001_0_1_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, 10'b001_0_1_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, 10'b001_0_1_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, 10'b010_0_0_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, 10'b010_0_0_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_0_1_0_0_0_0, 10'b011_1_0_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_1_1_0_0_0_0, 10'b011_1_0_0_0_0_0_0});
        tbl.push_back('{9'b1_1_0_1_1_1_1_0_0, 10'b011_1_0_0_0_0_1_1});
        for (int i = 0; i < 6; i++) tbl.push_back('{9'b1_1_0_1_1_0_0_0_0, 10'b011_1_0_0_0_0_1_1});
        tbl.push_back('{9'b1_1_0_0_1_0_0_1_0, 10'b100_1_0_1_0_0_1_1});
        tbl.push_back('{9'b1_1_0_0_1_0_0_1_1, 10'b100_1_0_1_0_0_1_1});
        tbl.push_back('{9'b1_1_0_0_1_0_0_1_1, 10'b100_1_0_1_0_0_1_1});
        tbl.push_back('{9'b1_1_0_1_1_0_0_1_0, 10'b100_1_0_1_0_0_1_1});
        tbl.push_back('{9'b1_1_0_0_1_0_0_1_1, 10'b100_1_0_1_0_0_1_1});
        tbl.push_back('{9'b1_1_0_0_1_0_0_1_1, 10'b100_1_0_1_0_0_1_1});
        tbl.push_back('{9'b1_1_0_0_1_0_0_1_1, E_LL_D1});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, E_CLR_D1});
        tbl.push_back('{9'b1_1_1_0_0_0_0_0_0, E_CLR_D1});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, E_CLR_D1});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, E_CLR_D1});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, E_CLR_D1});
        tbl.push_back('{9'b1_1_0_0_0_0_0_0_0, E_ACQ_D1});
        tbl.push_back('{9'b1_1_0_0_1_0_0_0_0, E_TRK_D1});

        #12;
        check("reset_state", w_out, 10'b0);
        arst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("main[%0d]", i), tbl[i].stim, tbl[i].exp);
        end

        // Timeout on the fifth event
        acquire_timeout_i = 16'd5;
        for (int i = 0; i < 4; i++) apply("timeout_pre", S_RV_EV, E_TRK_D1);
        apply("timeout_fire", S_RV_EV, E_TO_D1);
        apply("timeout_pulse_end", S_RV, E_CLR_D1);
        for (int i = 0; i < 2; i++) apply("timeout_clear", S_RV, E_CLR_D1);
        apply("timeout_acq", S_RV, E_ACQ_D1);
        apply("timeout_trk", S_RV, E_TRK_D1);

        // Timeout disabled: stays in TRACK
        acquire_timeout_i = 16'd0;
        for (int i = 0; i < 100; i++) apply("no_timeout", S_RV_EV, E_TRK_D1);

        // Clock enable: gated events, lock and drift must not register
        apply("restart_trk", 9'b1_1_1_0_1_0_0_0_0, E_CLR_D1);
        finish_clear_to_track("ce_setup");
        acquire_timeout_i = 16'd5;
        for (int i = 0; i < 2; i++) apply("ce_pre_events", S_RV_EV, E_TRK_D1);
        for (int i = 0; i < 20; i++) apply("ce_gated", 9'b0_1_0_1_1_1_0_1_0, E_TRK_D1);
        for (int i = 0; i < 2; i++) apply("ce_post_events", S_RV_EV, E_TRK_D1);
        apply("ce_timeout", S_RV_EV, E_TO_D1);
        finish_clear_to_track("ce_recover");

        // Disable from TRACK, restart ignored in IDLE
        apply("disable_trk", 9'b1_0_0_1_1_0_0_0_0, 10'b000_0_0_0_0_0_1_0);
        apply("restart_idle", 9'b1_0_1_0_0_0_0_0_0, 10'b000_0_0_0_0_0_1_0);

        // Lock, then lose it by locked_in falling
        apply("reen_clear", S_RV, E_CLR_D1);
        finish_clear_to_track("reen");
        apply("relock", S_RV_LI, E_LCK_D1);
        apply("lockin_fall", S_RV, E_LL_D1);

        // max_violations = 0: first violation drops lock
        max_violations_i = 4'd0;
        finish_clear_to_track("viol0_setup");
        apply("viol0_lock", S_RV_LI, E_LCK_D1);
        apply("viol0_drop", 9'b1_1_0_0_1_0_0_1_1, E_LL_D1);

        // Drift capture in LOCKED, then async reset
        finish_clear_to_track("ar_setup");
        apply("ar_lock", S_RV_LI, E_LCK_D1);
        apply("drift_locked", 9'b1_1_0_0_1_1_0_1_0, 10'b100_1_0_1_0_0_0_1);
        apply("drift_locked_hold", S_RV_LI, 10'b100_1_0_1_0_0_0_1);
        #2;
        arst_n = 1'b0;
        #1;
        check("async_reset", w_out, 10'b0);
        #10;
        check("reset_held", w_out, 10'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
